uart_tx_drain: RTL and testbench

UART_TX_DRAIN -- requirements
Module: uart_tx_drain

---
 rtl/uart_tx_drain.sv | 146 ++++++++++++++
 tb/tb_uart_tx_drain.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains bytes from a FIFO: pops one byte per frame and sends 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_drain #(
    parameter int BAUD_DIV = 10416
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iEmpty,
    input  logic [7:0] iRdData,
    output logic       oPop,
    output logic       oTx,
    output logic       oBusy,
    output logic       oDone
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    localparam logic [15:0] BIT_LAST = 16'(BAUD_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [2:0]  idx_q,   idx_d;
    logic [7:0]  shift_q, shift_d;
    logic        pop_q,   pop_d;
    logic        tx_q,    tx_d;
    logic        done_q,  done_d;
`ifdef UART_TX_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic bit_end;
    assign bit_end = (timer_q == BIT_LAST);

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        pop_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif

        if (state_q != IDLE) begin
            timer_d = bit_end ? 16'd0 : timer_q + 16'd1;
        end

        case (state_q)
            IDLE: begin
                if (!iEmpty) begin
                    state_d  = START;
                    shift_d  = iRdData;
                    timer_d  = 16'd0;
                    idx_d    = 3'd0;
                    pop_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^iRdData;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    idx_d   = 3'd0;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The line level is computed for the state being entered so oTx can come straight from a flop.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase

        done_d = (state_d == STOP) && (timer_d == BIT_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q  <= IDLE;
            timer_q  <= 16'd0;
            idx_q    <= 3'd0;
            shift_q  <= 8'd0;
            pop_q    <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            pop_q    <= pop_d;
            tx_q     <= tx_d;
            done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign oPop  = pop_q;
    assign oTx   = tx_q;
    assign oDone = done_q;
    assign oBusy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain at BAUD_DIV=4 with a small FIFO model feeding the transmitter.
// Build with UART_TX_PARITY_EN defined to exercise the parity-bit frame format.
`timescale 1ns/1ps
module tb_uart_tx_drain;

    localparam int BD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME  = NBITS * BD;
    localparam int PERIOD = FRAME + 1;

    logic       iClk = 1'b0;
    logic       iRst;
    logic       iEmpty;
    logic [7:0] iRdData;
    logic       oPop, oTx, oBusy, oDone;

    int n_checks = 0;
    int n_errors = 0;

    // FIFO model: active when fifo_mode=1, otherwise inputs come from drv_* directly.
    logic       fifo_mode;
    logic [7:0] fifo_mem [0:7];
    int         fifo_cnt;
    int         rd_ptr;
    logic       drv_empty;
    logic [7:0] drv_data;

    logic tx_s   [0:511];
    logic pop_s  [0:511];
    logic done_s [0:511];
    logic busy_s [0:511];

    always #5 iClk = ~iClk;

    assign iEmpty  = fifo_mode ? (rd_ptr >= fifo_cnt) : drv_empty;
    assign iRdData = fifo_mode ? fifo_mem[rd_ptr[2:0]] : drv_data;

    always @(posedge iClk) begin
        if (!fifo_mode)  rd_ptr <= 0;
        else if (oPop)   rd_ptr <= rd_ptr + 1;
    end

    uart_tx_drain #(.BAUD_DIV(BD)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iEmpty  (iEmpty),
        .iRdData (iRdData),
        .oPop    (oPop),
        .oTx     (oTx),
        .oBusy   (oBusy),
        .oDone   (oDone)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Index 0 is the first negedge after the edge that would start a frame.
    task automatic capture(input int ncyc, input bit scramble);
        for (int k = 0; k < ncyc; k++) begin
            @(negedge iClk);
            tx_s[k]   = oTx;
            pop_s[k]  = oPop;
            done_s[k] = oDone;
            busy_s[k] = oBusy;
            if (scramble) begin
                drv_data  = 8'($urandom);
                drv_empty = 1'($urandom);
            end
        end
    endtask

    task automatic count_pops(input int ncyc, output int n);
        n = 0;
        for (int k = 0; k < ncyc; k++) if (pop_s[k] === 1'b1) n++;
    endtask

    task automatic start_fifo(input int n);
        fifo_mode = 1'b0;
        @(negedge iClk);
        fifo_cnt  = n;
        fifo_mode = 1'b1;
    endtask

    task automatic check_frame(input int s, input logic [7:0] b, input string name);
        logic exp_bits [0:11];
        int   bad_tx = 0;
        int   n_pop  = 0;
        int   n_done = 0;
        int   n_idle = 0;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = b[i];
        exp_bits[9]       = ^b;
        exp_bits[NBITS-1] = 1'b1;
        for (int i = 0; i < NBITS; i++) begin
            for (int c = 0; c < BD; c++)
                if (tx_s[s + i*BD + c] !== exp_bits[i]) bad_tx++;
            check($sformatf("%s bit%0d", name, i), 32'(tx_s[s + i*BD + 1]), 32'(exp_bits[i]));
        end
        for (int k = s; k < s + FRAME; k++) begin
            if (pop_s[k]  === 1'b1) n_pop++;
            if (done_s[k] === 1'b1) n_done++;
            if (busy_s[k] !== 1'b1) n_idle++;
        end
        check($sformatf("%s tx_unstable_cycles", name), 32'(bad_tx), 32'd0);
        check($sformatf("%s pop_first_cycle", name), 32'(pop_s[s]), 32'd1);
        check($sformatf("%s pop_count", name), 32'(n_pop), 32'd1);
        check($sformatf("%s done_last_cycle", name), 32'(done_s[s + FRAME - 1]), 32'd1);
        check($sformatf("%s done_count", name), 32'(n_done), 32'd1);
        check($sformatf("%s busy_gaps", name), 32'(n_idle), 32'd0);
        check($sformatf("%s idle_busy", name), 32'(busy_s[s + FRAME]), 32'd0);
        check($sformatf("%s idle_tx", name), 32'(tx_s[s + FRAME]), 32'd1);
    endtask

    initial begin
        int bad;
        int npop;

        iRst      = 1'b1;
        fifo_mode = 1'b0;
        fifo_cnt  = 0;
        drv_empty = 1'b1;
        drv_data  = 8'h00;
        for (int i = 0; i < 8; i++) fifo_mem[i] = 8'h00;

        // Reset state
        repeat (3) @(negedge iClk);
        check("rst oTx",   32'(oTx),   32'd1);
        check("rst oPop",  32'(oPop),  32'd0);
        check("rst oBusy", 32'(oBusy), 32'd0);
        check("rst oDone", 32'(oDone), 32'd0);
        iRst = 1'b0;

        // Empty FIFO: line stays idle
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge iClk);
            if (oTx !== 1'b1 || oPop !== 1'b0 || oBusy !== 1'b0 || oDone !== 1'b0) bad++;
        end
        check("idle_100 bad_cycles", 32'(bad), 32'd0);

        // Single byte 0xA5
        fifo_mem[0] = 8'hA5;
        start_fifo(1);
        capture(PERIOD + 2, 1'b0);
        count_pops(PERIOD + 2, npop);
        check("a5 total_pops", 32'(npop), 32'd1);
        check_frame(0, 8'hA5, "a5");

        // Three queued bytes back to back
        fifo_mem[0] = 8'h00;
        fifo_mem[1] = 8'hFF;
        fifo_mem[2] = 8'h55;
        start_fifo(3);
        capture(3*PERIOD + 5, 1'b0);
        count_pops(3*PERIOD + 5, npop);
        check("q3 total_pops", 32'(npop), 32'd3);
        check("q3 pop_at_period",   32'(pop_s[PERIOD]),     32'd1);
        check("q3 pop_at_2period",  32'(pop_s[2*PERIOD]),   32'd1);
        check_frame(0,        8'h00, "q3_b0");
        check_frame(PERIOD,   8'hFF, "q3_b1");
        check_frame(2*PERIOD, 8'h55, "q3_b2");

        // Parity-sensitive bytes 0x07 (odd weight) and 0x03 (even weight)
        fifo_mem[0] = 8'h07;
        fifo_mem[1] = 8'h03;
        start_fifo(2);
        capture(2*PERIOD + 3, 1'b0);
        check_frame(0,      8'h07, "p07");
        check_frame(PERIOD, 8'h03, "p03");
`ifdef UART_TX_PARITY_EN
        check("p07 parity_bit", 32'(tx_s[9*BD + 2]),          32'd1);
        check("p03 parity_bit", 32'(tx_s[PERIOD + 9*BD + 2]), 32'd0);
`endif

        // Reset during data bit 3 of a 0x00 frame, then a fresh frame for 0x3C
        fifo_mem[0] = 8'h00;
        fifo_mem[1] = 8'h3C;
        start_fifo(2);
        capture(4*BD + 2, 1'b0);
        check("mid tx_before_rst",   32'(tx_s[4*BD + 1]),   32'd0);
        check("mid busy_before_rst", 32'(busy_s[4*BD + 1]), 32'd1);
        iRst = 1'b1;
        #1;
        check("mid rst oTx",   32'(oTx),   32'd1);
        check("mid rst oBusy", 32'(oBusy), 32'd0);
        check("mid rst oPop",  32'(oPop),  32'd0);
        check("mid rst oDone", 32'(oDone), 32'd0);
        bad = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge iClk);
            if (oPop !== 1'b0 || oBusy !== 1'b0 || oTx !== 1'b1) bad++;
        end
        check("mid held_rst bad_cycles", 32'(bad), 32'd0);
        iRst = 1'b0;
        capture(PERIOD + 1, 1'b0);
        check_frame(0, 8'h3C, "after_rst");

        // Inputs scrambled while a 0xC6 frame is in flight
        fifo_mode = 1'b0;
        drv_empty = 1'b1;
        @(negedge iClk);
        drv_data  = 8'hC6;
        drv_empty = 1'b0;
        capture(FRAME + 1, 1'b1);
        drv_empty = 1'b1;
        check_frame(0, 8'hC6, "scramble");

        repeat (BD * 2) @(negedge iClk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
